// File: rtl/wavelength_sequencer.sv
// Alternates the 730 nm and 850 nm LEDs around a shared amplitude collector and
// reports the per-channel peak amplitude of each completed frame over a valid/ack handshake.
module wavelength_sequencer #(
  parameter int SETTLE = 16,
  parameter int NSAMP  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] samp,
  input  logic       samp_rdy,
  output logic       led730,
  output logic       led850,
  output logic [3:0] max730,
  output logic [3:0] max850,
  output logic       out_valid,
  input  logic       out_ack,
  output logic       busy,
  output logic [2:0] state_dbg
);

  // Handshake: the result pair is transferred on a rising edge where out_valid and
  // out_ack are both 1; out_ack with out_valid low is ignored, and max730/max850
  // do not change while out_valid is high.

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int NW = $clog2(NSAMP + 1);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE - 1);
  localparam logic [NW-1:0] NSAMP_C  = NW'(NSAMP);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SET730 = 3'd1,
    ACQ730 = 3'd2,
    SET850 = 3'd3,
    ACQ850 = 3'd4,
    REPORT = 3'd5
  } state_t;

  state_t        state, state_n;
  logic [SW-1:0] scnt, scnt_n;
  logic [NW-1:0] ncnt, ncnt_n, ncnt_inc;
  logic [3:0]    run730, run730_n;
  logic [3:0]    run850, run850_n;
  logic [3:0]    max730_n, max850_n;

  assign ncnt_inc  = ncnt + NW'(1);
  assign state_dbg = state;

  always_comb begin
    state_n  = state;
    scnt_n   = scnt;
    ncnt_n   = ncnt;
    run730_n = run730;
    run850_n = run850;
    max730_n = max730;
    max850_n = max850;
    case (state)
      IDLE: begin
        if (en) begin
          state_n = SET730;
          scnt_n  = '0;
        end
      end
      SET730: begin
        if (scnt == SET_LAST) begin
          state_n  = ACQ730;
          ncnt_n   = '0;
          run730_n = '0;
        end else begin
          scnt_n = scnt + SW'(1);
        end
      end
      ACQ730: begin
        if (samp_rdy) begin
          if (samp > run730) run730_n = samp;
          ncnt_n = ncnt_inc;
          if (ncnt_inc == NSAMP_C) begin
            state_n = SET850;
            scnt_n  = '0;
          end
        end
      end
      SET850: begin
        if (scnt == SET_LAST) begin
          state_n  = ACQ850;
          ncnt_n   = '0;
          run850_n = '0;
        end else begin
          scnt_n = scnt + SW'(1);
        end
      end
      ACQ850: begin
        if (samp_rdy) begin
          if (samp > run850) run850_n = samp;
          ncnt_n = ncnt_inc;
          // The last strobe's sample goes straight into the reported peak.
          if (ncnt_inc == NSAMP_C) begin
            state_n  = REPORT;
            max730_n = run730;
            max850_n = run850_n;
          end
        end
      end
      REPORT: begin
        if (out_valid && out_ack) begin
          state_n = en ? SET730 : IDLE;
          scnt_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      scnt      <= '0;
      ncnt      <= '0;
      run730    <= '0;
      run850    <= '0;
      max730    <= 4'h0;
      max850    <= 4'h0;
      led730    <= 1'b0;
      led850    <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      scnt      <= scnt_n;
      ncnt      <= ncnt_n;
      run730    <= run730_n;
      run850    <= run850_n;
      max730    <= max730_n;
      max850    <= max850_n;
      led730    <= (state_n == SET730) || (state_n == ACQ730);
      led850    <= (state_n == SET850) || (state_n == ACQ850);
      out_valid <= (state_n == REPORT);
      busy      <= (state_n != IDLE);
    end
  end

endmodule
